oled_sequencer: RTL and testbench

OLED_SEQUENCER -- requirements
Module: oled_sequencer

---
 rtl/oled_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_oled_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_sequencer.sv
// Power-up sequencer for an SSD1306-style OLED panel: rails, reset pulse and init
// commands through a 4-phase SPI byte handshake, then a host byte-write pass-through.
module oled_sequencer #(
  parameter int DLY_SHORT = 100000,
  parameter int DLY_LONG  = 10000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  input  logic       wr_dc,
  output logic       wr_ready,
  output logic [7:0] spi_byte,
  output logic       load_data,
  input  logic       done_send,
  output logic       oled_dc,
  output logic       oled_res_n,
  output logic       oled_vdd_n,
  output logic       oled_vbat_n,
  output logic       init_done,
  output logic [3:0] state_dbg
);

  localparam int CW = $clog2(DLY_LONG + 1);
  localparam logic [CW-1:0] SHORT_N = CW'(DLY_SHORT);
  localparam logic [CW-1:0] LONG_N  = CW'(DLY_LONG);

  typedef enum logic [3:0] {
    IDLE, VDD_ON, WAIT, SEND, ACK, REL, RES_LO, RES_HI, VBAT_ON, READY, HOST_TX
  } state_t;

  // Host handshake: wr_valid && wr_ready in the same cycle transfers one byte;
  // wr_ready is low for the whole SPI handshake, and wr_valid seen then is dropped.

  function automatic logic [7:0] rom(input logic [3:0] idx);
    case (idx)
      4'd0:    rom = 8'hAE;
      4'd1:    rom = 8'h8D;
      4'd2:    rom = 8'h14;
      4'd3:    rom = 8'hD9;
      4'd4:    rom = 8'hF1;
      4'd5:    rom = 8'h81;
      4'd6:    rom = 8'h0F;
      4'd7:    rom = 8'hA1;
      4'd8:    rom = 8'hC8;
      4'd9:    rom = 8'hDA;
      4'd10:   rom = 8'h20;
      4'd11:   rom = 8'hAF;
      default: rom = 8'h00;
    endcase
  endfunction

  state_t          state_q, state_d, ret_q, ret_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync1_q, sync1_d, ds_q, ds_d;
  logic            load_q, load_d, dc_q, dc_d, host_q, host_d;
  logic [7:0]      byte_q, byte_d;
  logic            res_n_q, res_n_d, vdd_n_q, vdd_n_d, vbat_n_q, vbat_n_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ret_q    <= IDLE;
      ptr_q    <= 4'd0;
      cnt_q    <= '0;
      sync1_q  <= 1'b0;
      ds_q     <= 1'b0;
      load_q   <= 1'b0;
      dc_q     <= 1'b0;
      host_q   <= 1'b0;
      byte_q   <= 8'h00;
      res_n_q  <= 1'b1;
      vdd_n_q  <= 1'b1;
      vbat_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      sync1_q  <= sync1_d;
      ds_q     <= ds_d;
      load_q   <= load_d;
      dc_q     <= dc_d;
      host_q   <= host_d;
      byte_q   <= byte_d;
      res_n_q  <= res_n_d;
      vdd_n_q  <= vdd_n_d;
      vbat_n_q <= vbat_n_d;
    end
  end

  // Edges that enter SEND/HOST_TX also raise load_data when no stale completion
  // flag is pending, so a byte goes out on the same edge its wait/capture ends.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    sync1_d  = done_send;
    ds_d     = sync1_q;
    load_d   = load_q;
    dc_d     = dc_q;
    host_d   = host_q;
    byte_d   = byte_q;
    res_n_d  = res_n_q;
    vdd_n_d  = vdd_n_q;
    vbat_n_d = vbat_n_q;
    case (state_q)
      IDLE: if (start) state_d = VDD_ON;
      VDD_ON: begin
        vdd_n_d = 1'b0;
        cnt_d   = SHORT_N;
        ret_d   = SEND;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (ret_q == RES_HI) begin
            res_n_d = 1'b1;
            state_d = RES_HI;
          end else begin
            byte_d  = rom(ptr_q);
            dc_d    = 1'b0;
            load_d  = !ds_q;
            state_d = SEND;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SEND, HOST_TX: begin
        if (!load_q) begin
          if (!ds_q) load_d = 1'b1;
        end else if (ds_q) begin
          load_d  = 1'b0;
          state_d = ACK;
        end
      end
      ACK: if (!ds_q) state_d = REL;
      REL: begin
        if (host_q) begin
          host_d  = 1'b0;
          state_d = READY;
        end else begin
          case (ptr_q)
            4'd0:    state_d = RES_LO;
            4'd4:    state_d = VBAT_ON;
            4'd11:   state_d = READY;
            default: begin
              byte_d  = rom(ptr_q + 4'd1);
              dc_d    = 1'b0;
              load_d  = !ds_q;
              state_d = SEND;
            end
          endcase
          if (ptr_q != 4'd11) ptr_d = ptr_q + 4'd1;
        end
      end
      RES_LO: begin
        res_n_d = 1'b0;
        cnt_d   = SHORT_N;
        ret_d   = RES_HI;
        state_d = WAIT;
      end
      RES_HI: begin
        cnt_d   = SHORT_N;
        ret_d   = SEND;
        state_d = WAIT;
      end
      VBAT_ON: begin
        vbat_n_d = 1'b0;
        cnt_d    = LONG_N;
        ret_d    = SEND;
        state_d  = WAIT;
      end
      READY: begin
        if (wr_valid) begin
          byte_d  = wr_data;
          dc_d    = wr_dc;
          host_d  = 1'b1;
          load_d  = !ds_q;
          state_d = HOST_TX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ready    = (state_q == READY);
  assign init_done   = (state_q == READY);
  assign spi_byte    = byte_q;
  assign load_data   = load_q;
  assign oled_dc     = dc_q;
  assign oled_res_n  = res_n_q;
  assign oled_vdd_n  = vdd_n_q;
  assign oled_vbat_n = vbat_n_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_oled_sequencer.sv
// Scoreboard bench for oled_sequencer: stimulus pushes expected {dc,byte} pairs,
// a negedge monitor pops them on each load_data rise; a behavioural SPI sender answers.
module tb_oled_sequencer;

  localparam int DS = 10;
  localparam int DL = 50;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_HOST_TX = 4'd10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_dc = 1'b0;
  logic       done_send = 1'b0;
  logic       wr_ready, load_data, oled_dc, oled_res_n, oled_vdd_n, oled_vbat_n, init_done;
  logic [7:0] spi_byte;
  logic [3:0] state_dbg;

  oled_sequencer #(.DLY_SHORT(DS), .DLY_LONG(DL)) dut (
    .clock(clock), .reset(reset), .start(start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_dc(wr_dc), .wr_ready(wr_ready),
    .spi_byte(spi_byte), .load_data(load_data), .done_send(done_send),
    .oled_dc(oled_dc), .oled_res_n(oled_res_n), .oled_vdd_n(oled_vdd_n),
    .oled_vbat_n(oled_vbat_n), .init_done(init_done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_fail = 0;
  int n_done = 0;
  logic [8:0] exp_q[$];
  logic [7:0] init_rom[12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81,
                               8'h0F, 8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_init(input int count);
    for (int i = 0; i < count; i++) exp_q.push_back({1'b0, init_rom[i]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // behavioural SPI sender: done high 20 cycles after load, low 3 cycles after release
  logic resp_manual = 1'b0;
  logic man_level = 1'b0;
  int hi_cnt = 0;
  int lo_cnt = 0;
  always @(posedge clock) begin
    #2;
    if (resp_manual) begin
      done_send = man_level;
      hi_cnt = 0;
      lo_cnt = 0;
    end else if (load_data) begin
      lo_cnt = 0;
      if (!done_send) begin
        hi_cnt++;
        if (hi_cnt >= 20) done_send = 1'b1;
      end
    end else begin
      hi_cnt = 0;
      if (done_send) begin
        lo_cnt++;
        if (lo_cnt >= 3) done_send = 1'b0;
      end
    end
  end

  // scoreboard monitor: byte/dc at load rise, stability at completion
  logic       prev_load = 1'b0;
  logic       prev_done = 1'b0;
  logic       in_flight = 1'b0;
  logic [8:0] held = '0;
  always @(negedge clock) begin
    if (reset) begin
      in_flight = 1'b0;
      prev_load = 1'b0;
    end else begin
      if (load_data && !prev_load) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {23'd0, oled_dc, spi_byte}, 32'h1ff);
        end else begin
          chk("byte", {23'd0, oled_dc, spi_byte}, {23'd0, exp_q.pop_front()});
        end
        held = {oled_dc, spi_byte};
        in_flight = 1'b1;
      end
      if (!done_send && prev_done && in_flight) begin
        chk("byte_stable", {23'd0, oled_dc, spi_byte}, {23'd0, held});
        in_flight = 1'b0;
        n_done++;
      end
      prev_load = load_data;
    end
    prev_done = done_send;
  end

  // stimulus
  int t0, base;
  logic load_seen;
  initial begin
    repeat (3) @(negedge clock);
    chk("rst_load", 32'(load_data), 32'd0);
    chk("rst_byte", 32'(spi_byte), 32'd0);
    chk("rst_dc", 32'(oled_dc), 32'd0);
    chk("rst_res_n", 32'(oled_res_n), 32'd1);
    chk("rst_vdd_n", 32'(oled_vdd_n), 32'd1);
    chk("rst_vbat_n", 32'(oled_vbat_n), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("idle_no_start", 32'(oled_vdd_n), 32'd1);

    // full init with start re-pulsed during the waits
    base = n_done;
    push_init(12);
    pulse_start();
    for (int i = 0; i < 10 && oled_vdd_n !== 1'b0; i++) @(negedge clock);
    chk("vdd_fall", 32'(oled_vdd_n), 32'd0);
    t0 = cyc;
    repeat (3) @(negedge clock);
    pulse_start();
    for (int i = 0; i < 40 && load_data !== 1'b1; i++) @(negedge clock);
    chk("vdd_to_ae_cycles", 32'(cyc - t0), 32'd11);
    for (int i = 0; i < 200 && oled_res_n !== 1'b0; i++) @(negedge clock);
    chk("res_fall", 32'(oled_res_n), 32'd0);
    t0 = cyc;
    for (int i = 0; i < 40 && oled_res_n !== 1'b1; i++) @(negedge clock);
    chk("res_low_cycles", 32'(cyc - t0), 32'd11);
    t0 = cyc;
    for (int i = 0; i < 40 && load_data !== 1'b1; i++) @(negedge clock);
    chk("res_hi_to_8d_cycles", 32'(cyc - t0), 32'd12);
    for (int i = 0; i < 1000 && oled_vbat_n !== 1'b0; i++) @(negedge clock);
    chk("vbat_fall", 32'(oled_vbat_n), 32'd0);
    chk("bytes_before_vbat", 32'(n_done - base), 32'd5);
    chk("idle_link_at_vbat", 32'(in_flight), 32'd0);
    t0 = cyc;
    repeat (5) @(negedge clock);
    pulse_start();
    for (int i = 0; i < 100 && load_data !== 1'b1; i++) @(negedge clock);
    chk("vbat_to_81_cycles", 32'(cyc - t0), 32'd51);
    for (int i = 0; i < 2000 && init_done !== 1'b1; i++) @(negedge clock);
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_bytes", 32'(n_done - base), 32'd12);
    chk("init_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("ready_after_init", 32'(wr_ready), 32'd1);
    chk("rails_held", {29'd0, oled_vdd_n, oled_vbat_n, oled_res_n}, 32'd1);

    // host data byte
    base = n_done;
    exp_q.push_back({1'b1, 8'hA5});
    wr_data = 8'hA5;
    wr_dc = 1'b1;
    wr_valid = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0;
    chk("host_ready_drop", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 50 && done_send !== 1'b1; i++) @(negedge clock);
    for (int i = 0; i < 50 && done_send !== 1'b0; i++) @(negedge clock);
    chk("host_ready_low_at_done_fall", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 10 && wr_ready !== 1'b1; i++) @(negedge clock);
    chk("host_ready_back", 32'(wr_ready), 32'd1);

    // wr_valid held through a transfer: second byte sent exactly once
    exp_q.push_back({1'b0, 8'h55});
    wr_data = 8'h55;
    wr_dc = 1'b0;
    wr_valid = 1'b1;
    @(negedge clock);
    wr_data = 8'h3C;
    exp_q.push_back({1'b0, 8'h3C});
    chk("hold_ready_low", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 200 && wr_ready !== 1'b1; i++) @(negedge clock);
    chk("hold_ready_back", 32'(wr_ready), 32'd1);
    @(negedge clock);
    wr_valid = 1'b0;
    chk("hold_captured", 32'(state_dbg), 32'(ST_HOST_TX));
    for (int i = 0; i < 200 && wr_ready !== 1'b1; i++) @(negedge clock);
    repeat (30) @(negedge clock);
    chk("host_bytes", 32'(n_done - base), 32'd3);
    chk("host_queue_empty", 32'(exp_q.size()), 32'd0);

    // reset in the middle of the 0x14 handshake, restart with done_send stuck high
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    push_init(3);
    pulse_start();
    for (int i = 0; i < 1000 && !(load_data === 1'b1 && spi_byte === 8'h14); i++)
      @(negedge clock);
    for (int i = 0; i < 40 && done_send !== 1'b1; i++) @(negedge clock);
    chk("pre_reset_load", 32'(load_data), 32'd1);
    man_level = 1'b1;
    resp_manual = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_load", 32'(load_data), 32'd0);
    chk("mid_rst_byte", 32'(spi_byte), 32'd0);
    chk("mid_rst_rails", {29'd0, oled_vdd_n, oled_vbat_n, oled_res_n}, 32'd7);
    chk("mid_rst_flags", {29'd0, oled_dc, wr_ready, init_done}, 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    base = n_done;
    push_init(12);
    pulse_start();
    load_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (load_data) load_seen = 1'b1;
    end
    chk("stale_no_load", 32'(load_seen), 32'd0);
    man_level = 1'b0;
    for (int i = 0; i < 10 && load_data !== 1'b1; i++) @(negedge clock);
    chk("stale_release_load", 32'(load_data), 32'd1);
    resp_manual = 1'b0;
    for (int i = 0; i < 3000 && init_done !== 1'b1; i++) @(negedge clock);
    chk("reinit_done", 32'(init_done), 32'd1);
    chk("reinit_bytes", 32'(n_done - base), 32'd12);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
